// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for data_mem_arbiter and its sub-blocks.
//   DEFAULT_MEM_WORDS : default data_mem depth in 32-bit words
//   MASTER_0/MASTER_1 : master index constants (1-bit owner encoding)
//   rsp_t             : registered response slot (valid, err, owner, rd)
package mem_pkg;

    localparam int unsigned DEFAULT_MEM_WORDS = 1024;

    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

    typedef struct packed {
        logic valid;  // a granted access is awaiting its response
        logic err;    // access was misaligned or out of range
        logic owner;  // master that the response belongs to
        logic rd;     // access was a read, so rdata comes from memory
    } rsp_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: request/response bus between one master and the arbiter.
//   req/we/lock/addr/wdata : driven by the master
//   gnt                    : combinational accept from the arbiter
//   rvalid/rdata/err       : one-cycle response, the cycle after gnt
interface data_mem_arbiter_if;

    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: purely combinational two-way round-robin arbiter with lock.
//   req_i        : request per master
//   lock_valid_i : a lock owner exists
//   lock_owner_i : index of the lock owner
//   last_grant_i : index of the most recently granted master
//   gnt_o        : one-hot (or zero) grant
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       lock_valid_i,
    input  logic       lock_owner_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (lock_valid_i) begin
            // Only the owner may proceed; the other master is starved.
            if (lock_owner_i) begin
                gnt_o[1] = req_i[1];
            end else begin
                gnt_o[0] = req_i[0];
            end
        end else if (&req_i) begin
            // Contention: the master not granted most recently wins.
            if (last_grant_i) begin
                gnt_o = 2'b01;
            end else begin
                gnt_o = 2'b10;
            end
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares single-port data_mem between two masters.
//   clk, rst_n      : clock, asynchronous active-low reset
//   m0, m1          : master buses (slave side), m0 = core LSU, m1 = DMA/debug
//   mem_addr        : byte address to data_mem (held while idle)
//   mem_write_data  : write data to data_mem (held while idle)
//   mem_we          : write enable, only for legal granted writes
//   mem_read_data   : data_mem read data, valid one cycle after address
// Illegal accesses (misaligned or beyond the memory) never reach memory and
// respond with err=1, rdata=0.
module data_mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    data_mem_arbiter_if.slave         m0,
    data_mem_arbiter_if.slave         m1,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_write_data,
    output logic                      mem_we,
    input  logic [31:0]               mem_read_data
);

    // 33 bits so the limit is representable for any legal MEM_WORDS.
    localparam logic [32:0] AddrLimit = 33'(MEM_WORDS) << 2;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        granted;
    logic        winner;
    logic        win_we;
    logic        win_lock;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        legal;
    logic [31:0] rsp_rdata;

    logic        last_grant_q, last_grant_d;
    logic        lock_valid_q, lock_valid_d;
    logic        lock_owner_q, lock_owner_d;
    rsp_t        rsp_q, rsp_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // Gate requests with reset so no grant (and no memory write) can occur
    // while rst_n is low, even if masters keep requesting.
    assign req = {m1.req, m0.req} & {2{rst_n}};

    rr_arbiter2 u_arb (
        .req_i        (req),
        .lock_valid_i (lock_valid_q),
        .lock_owner_i (lock_owner_q),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    // Winner mux and legality check.
    always_comb begin
        granted   = |gnt;
        winner    = gnt[1] ? MASTER_1 : MASTER_0;
        win_we    = winner ? m1.we    : m0.we;
        win_lock  = winner ? m1.lock  : m0.lock;
        win_addr  = winner ? m1.addr  : m0.addr;
        win_wdata = winner ? m1.wdata : m0.wdata;
        legal     = (win_addr[1:0] == 2'b00) && ({1'b0, win_addr} < AddrLimit);
    end

    // Next state.
    always_comb begin
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_d        = '0;
        if (granted) begin
            last_grant_d = winner;
            mem_addr_d   = win_addr;
            mem_wdata_d  = win_wdata;
            rsp_d.valid  = 1'b1;
            rsp_d.err    = ~legal;
            rsp_d.owner  = winner;
            rsp_d.rd     = ~win_we;
            if (win_lock) begin
                lock_valid_d = 1'b1;
                lock_owner_d = winner;
            end else if (lock_valid_q && (lock_owner_q == winner)) begin
                // Owner's unlocked access ends the locked sequence.
                lock_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= MASTER_1;  // master 0 wins the first contention
            lock_valid_q <= 1'b0;
            lock_owner_q <= MASTER_0;
            rsp_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            rsp_q        <= rsp_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Memory side: follow the winner, otherwise hold the last values.
    always_comb begin
        mem_addr       = granted ? win_addr  : mem_addr_q;
        mem_write_data = granted ? win_wdata : mem_wdata_q;
        mem_we         = granted && win_we && legal;
    end

    // Response routing.
    always_comb begin
        rsp_rdata = (rsp_q.valid && !rsp_q.err && rsp_q.rd) ? mem_read_data : 32'h0;
    end

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rvalid = rsp_q.valid && (rsp_q.owner == MASTER_0);
    assign m1.rvalid = rsp_q.valid && (rsp_q.owner == MASTER_1);
    assign m0.rdata  = m0.rvalid ? rsp_rdata : 32'h0;
    assign m1.rdata  = m1.rvalid ? rsp_rdata : 32'h0;
    assign m0.err    = m0.rvalid && rsp_q.err;
    assign m1.err    = m1.rvalid && rsp_q.err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a behavioural
// data_mem (registered read, write at the grant edge) and a reference array.
module tb_data_mem_arbiter;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int          N_TP      = 1021;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_we;
    logic [31:0] mem_read_data;

    data_mem_arbiter_if bus0 ();
    data_mem_arbiter_if bus1 ();

    data_mem_arbiter #(
        .MEM_WORDS (MEM_WORDS)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0             (bus0),
        .m1             (bus1),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_we         (mem_we),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_mem; cleared on its first edge.
    logic [31:0] mem [MEM_WORDS];
    bit          mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= 32'h0;
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_write_data;
        end
        mem_read_data <= mem[mem_addr[11:2]];
    end

    int          n_checks;
    int          n_pass;
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] tp_addr [N_TP];
    logic [31:0] tp_data [N_TP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int m, input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            bus0.req = req; bus0.we = we; bus0.lock = lock; bus0.addr = addr; bus0.wdata = wdata;
        end else begin
            bus1.req = req; bus1.we = we; bus1.lock = lock; bus1.addr = addr; bus1.wdata = wdata;
        end
    endtask

    task automatic idle_all();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? bus0.gnt : bus1.gnt;
    endfunction

    function automatic logic rvalid_of(input int m);
        return (m == 0) ? bus0.rvalid : bus1.rvalid;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? bus0.rdata : bus1.rdata;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 0) ? bus0.err : bus1.err;
    endfunction

    // Single read by master m, response checked against exp.
    task automatic read_chk(input string tag, input int m, input logic [31:0] addr,
                            input logic [31:0] exp);
        set_m(m, 1'b1, 1'b0, 1'b0, addr, 32'h0);
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt_of(m)), 32'd1);
        next_cycle();
        idle_all();
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(rvalid_of(m)), 32'd1);
        check({tag, "_rdata"}, rdata_of(m), exp);
        check({tag, "_err"}, 32'(err_of(m)), 32'd0);
        next_cycle();
    endtask

    // Illegal write by master 0: must not reach memory, responds with error.
    task automatic err_write(input string tag, input logic [31:0] addr);
        set_m(0, 1'b1, 1'b1, 1'b0, addr, 32'h1111_1111);
        @(negedge clk);
        check({tag, "_gnt"}, 32'(bus0.gnt), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        next_cycle();
        idle_all();
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(bus0.rvalid), 32'd1);
        check({tag, "_err"}, 32'(bus0.err), 32'd1);
        check({tag, "_rdata"}, bus0.rdata, 32'h0);
        check({tag, "_mem_we_rsp"}, 32'(mem_we), 32'd0);
        next_cycle();
    endtask

    initial begin
        int          pm;
        logic [31:0] pexp;
        logic        wr;
        int          m;
        int          k;

        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < N_TP; i++) begin
            tp_addr[i] = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            tp_data[i] = $urandom;
        end

        // ---- Reset state, with a write request pending on m0 ----
        rst_n = 1'b0;
        idle_all();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hAAAA_5555);
        #2;
        check("rst_gnt0", 32'(bus0.gnt), 32'd0);
        check("rst_gnt1", 32'(bus1.gnt), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        check("rst_rvalid0", 32'(bus0.rvalid), 32'd0);
        check("rst_rvalid1", 32'(bus1.rvalid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // ---- Single master write then read ----
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_gnt0", 32'(bus0.gnt), 32'd1);
        check("wr_gnt1", 32'(bus1.gnt), 32'd0);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", mem_addr, 32'h10);
        check("wr_mem_wdata", mem_write_data, 32'hDEAD_BEEF);
        next_cycle();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("rd_gnt0", 32'(bus0.gnt), 32'd1);
        check("wr_rvalid0", 32'(bus0.rvalid), 32'd1);
        check("wr_rdata0", bus0.rdata, 32'h0);
        check("wr_err0", 32'(bus0.err), 32'd0);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("rd_rvalid0", 32'(bus0.rvalid), 32'd1);
        check("rd_rdata0", bus0.rdata, 32'hDEAD_BEEF);
        check("rd_err0", 32'(bus0.err), 32'd0);
        check("rd_rvalid1", 32'(bus1.rvalid), 32'd0);
        check("idle_mem_we", 32'(mem_we), 32'd0);
        check("idle_mem_addr_hold", mem_addr, 32'h10);
        next_cycle();
        @(negedge clk);
        check("idle_rvalid0", 32'(bus0.rvalid), 32'd0);
        next_cycle();

        // ---- Errors ----
        err_write("err_misalign", 32'h13);
        err_write("err_range", 32'(4 * MEM_WORDS));
        read_chk("nb_0x10", 0, 32'h10, 32'hDEAD_BEEF);
        read_chk("nb_0x14", 0, 32'h14, 32'h0);
        read_chk("nb_0x00", 0, 32'h0, 32'h0);

        // ---- Lock ----
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        check("lk_rd_gnt1", 32'(bus1.gnt), 32'd1);
        next_cycle();
        // Owner drops req; m0 still must wait.
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("lk_hold_gnt0", 32'(bus0.gnt), 32'd0);
        check("lk_rd_rvalid1", 32'(bus1.rvalid), 32'd1);
        check("lk_rd_rdata1", bus1.rdata, 32'h0);
        next_cycle();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        check("lk_wr_gnt1", 32'(bus1.gnt), 32'd1);
        check("lk_wr_gnt0", 32'(bus0.gnt), 32'd0);
        next_cycle();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("lk_rel_gnt0", 32'(bus0.gnt), 32'd1);
        check("lk_wr_rvalid1", 32'(bus1.rvalid), 32'd1);
        check("lk_wr_err1", 32'(bus1.err), 32'd0);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("lk_m0_rvalid", 32'(bus0.rvalid), 32'd1);
        check("lk_m0_rdata", bus0.rdata, 32'hDEAD_BEEF);
        next_cycle();
        read_chk("lk_word", 0, 32'h20, 32'hCAFE_F00D);

        // ---- Reset mid-read ----
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        check("mr_gnt1", 32'(bus1.gnt), 32'd1);
        next_cycle();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h5555_AAAA);
        check("mr_rvalid_pre", 32'(bus1.rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_rvalid1", 32'(bus1.rvalid), 32'd0);
        check("mr_rdata1", bus1.rdata, 32'h0);
        check("mr_gnt0", 32'(bus0.gnt), 32'd0);
        check("mr_gnt1_rst", 32'(bus1.gnt), 32'd0);
        check("mr_mem_we", 32'(mem_we), 32'd0);
        check("mr_mem_addr", mem_addr, 32'h0);
        check("mr_mem_wdata", mem_write_data, 32'h0);
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // ---- Contention, continuous, right after release ----
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("ct_gnt0_%0d", i), 32'(bus0.gnt), 32'((i % 2) == 0));
            check($sformatf("ct_gnt1_%0d", i), 32'(bus1.gnt), 32'((i % 2) == 1));
            if (i == 0) begin
                check("ct_no_rvalid0", 32'(bus0.rvalid), 32'd0);
                check("ct_no_rvalid1", 32'(bus1.rvalid), 32'd0);
            end else begin
                pm   = (i - 1) % 2;
                pexp = (pm == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D;
                check($sformatf("ct_rvalid_%0d", i), 32'(rvalid_of(pm)), 32'd1);
                check($sformatf("ct_other_%0d", i), 32'(rvalid_of(1 - pm)), 32'd0);
                check($sformatf("ct_rdata_%0d", i), rdata_of(pm), pexp);
            end
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        check("ct_last_rvalid1", 32'(bus1.rvalid), 32'd1);
        check("ct_last_rdata1", bus1.rdata, 32'hCAFE_F00D);
        check("ct_last_rvalid0", 32'(bus0.rvalid), 32'd0);
        next_cycle();

        // ---- Throughput: writes then reads, alternating masters, one per cycle ----
        pm   = 0;
        pexp = 32'h0;
        for (int i = 0; i < 2 * N_TP; i++) begin
            m  = i % 2;
            k  = i % N_TP;
            wr = (i < N_TP);
            idle_all();
            set_m(m, 1'b1, wr, 1'b0, tp_addr[k], tp_data[k]);
            @(negedge clk);
            check($sformatf("tp_gnt_%0d", i), 32'(gnt_of(m)), 32'd1);
            if (i > 0) begin
                check($sformatf("tp_rvalid_%0d", i - 1), 32'(rvalid_of(pm)), 32'd1);
                check($sformatf("tp_rdata_%0d", i - 1), rdata_of(pm), pexp);
            end
            pm = m;
            if (wr) begin
                ref_mem[tp_addr[k][11:2]] = tp_data[k];
                pexp = 32'h0;
            end else begin
                pexp = ref_mem[tp_addr[k][11:2]];
            end
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        check("tp_rvalid_last", 32'(rvalid_of(pm)), 32'd1);
        check("tp_rdata_last", rdata_of(pm), pexp);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-master arbiter that shares the single-port `data_mem` between the core load/store unit (master 0) and a secondary requester such as DMA or debug (master 1). It uses round-robin arbitration, supports a per-master lock for read-modify-write sequences, and checks alignment and range before forwarding an access. Every granted access returns exactly one response the following cycle. The block sits directly in front of `data_mem`, and its memory-side ports connect 1:1 to the memory's `addr`/`write_data`/`WE`/`read_data`.

## Interface
- `MEM_WORDS`, 1024: memory depth in 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-1.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `m0_req` in 1 / `m1_req` in 1: access request, held until granted.
- `m0_we` in 1 / `m1_we` in 1: 1 = write, 0 = read.
- `m0_lock` in 1 / `m1_lock` in 1: keep ownership after this access.
- `m0_addr` in 32 / `m1_addr` in 32: byte address.
- `m0_wdata` in 32 / `m1_wdata` in 32: write data.
- `m0_gnt` out 1 / `m1_gnt` out 1: request accepted this cycle (combinational).
- `m0_rvalid` out 1 / `m1_rvalid` out 1: response valid; one-cycle pulse.
- `m0_rdata` out 32 / `m1_rdata` out 32: read data; 0 for writes and errors.
- `m0_err` out 1 / `m1_err` out 1: qualified by rvalid; access was misaligned or out of range.
- `mem_addr` out 32: byte address to `data_mem`.
- `mem_write_data` out 32: write data to `data_mem`.
- `mem_we` out 1: write enable to `data_mem`.
- `mem_read_data` in 32: `data_mem` read data, registered, valid one cycle after address.

## Operation
- **Arbitration each cycle**
  - If a lock owner exists, only the owner can be granted.
  - Otherwise, a single requester wins.
  - If both request, the master not granted most recently wins.
  - At most one gnt is high per cycle.
- **Granted access**
  - `mem_addr` and `mem_write_data` are driven from the winner.
  - `mem_we` = winner `we` AND access is legal.
  - An owner register records the winner and the error flag for the response.
- **Legality**
  - `addr[1:0]` must be 00.
  - `addr` must be < 4*MEM_WORDS.
  - On an illegal access: `mem_we` = 0 and no memory side effect; the response carries err=1 and rdata=0.
- **Idle cycle** (no grant)
  - `mem_we` = 0.
  - `mem_addr` and `mem_write_data` hold their last values (no toggling).
- **Response**
  - The cycle after a grant, the owner's rvalid = 1.
  - rdata = `mem_read_data` for legal reads, otherwise 0.
  - The other master's rvalid = 0.
- **Back-to-back accesses**: a new grant may occur in the same cycle as the previous response; the pipeline sustains one access per cycle.
- **Lock**
  - A granted access with lock=1 sets the owner to that master.
  - A granted access by the owner with lock=0 releases the lock after that access.
  - The owner dropping req does not release the lock.
  - While locked, the other master is starved by design.
- **Last-grant register**: updated on every grant.

## Timing
- **Reset values (async, immediate)**
  - All gnt outputs 0 while `rst_n` is low.
  - All rvalid and err outputs 0.
  - All rdata outputs 0.
  - `mem_we` 0.
  - `mem_addr` and `mem_write_data` 0.
  - last_grant = master 1, so master 0 wins the first contention.
  - Lock owner cleared.
- **Latency**: request to gnt is 0 cycles; gnt to rvalid is 1 cycle.
- **Write timing**: writes commit at the grant-cycle edge.
- **Simultaneous requests, unlocked**: grants alternate 0,1,0,1 under continuous contention.
- **Reset mid-access**: the pending response is dropped; no rvalid appears after reset release.
- **Reset release**: first grant possible in the first cycle after `rst_n` deasserts.

## Structure
- **Shared package `mem_pkg`**:
  - `MEM_WORDS` default.
  - `MASTER_0`/`MASTER_1` index constants.
  - Response struct fields: `valid`, `err`, `owner`.
- **Sub-module `rr_arbiter2`**:
  - Inputs: req[1:0], lock owner/valid, last_grant.
  - Output: one-hot gnt.
  - Purely combinational; the parent holds the registers.

## Test plan
- **Reset**: reset asserted mid-read → all outputs 0 immediately; no rvalid after release.
- **Single master**: m0 writes 0xDEADBEEF to 0x10, then reads 0x10 → m0_rvalid one cycle after gnt with rdata 0xDEADBEEF and err=0.
- **Contention**: m0_req and m1_req held for 6 cycles, all reads → grants 0,1,0,1,0,1; each rvalid is routed to the correct master with the correct rdata.
- **Lock**: m1 issues read 0x20 with lock=1, m0 requests, m1 then writes 0x20 with lock=0 → m0 is not granted until the cycle after m1's write grant; memory word 0x20 holds m1's data.
- **Errors**:
  - m0 writes to 0x13 → err=1, mem_we stays 0, rdata 0.
  - m0 writes to 4*MEM_WORDS → err=1, mem_we stays 0, rdata 0.
  - Subsequent reads of neighbouring words are unchanged.
- **Throughput**: 1021 random legal writes then reads from alternating masters → zero mismatches against a reference model, and one access completes per cycle.
